// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule controller: S-box, GF(2^8) doubling,
// word-level transforms, state/word-class enums and the legal key-length/round pairings.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } state_e;

    typedef enum logic [1:0] {
        WCLS_PLAIN,
        WCLS_ROTSUB,
        WCLS_SUB
    } wcls_e;

    localparam int NK_AES128 = 4;
    localparam int NR_AES128 = 10;
    localparam int NK_AES192 = 6;
    localparam int NR_AES192 = 12;
    localparam int NK_AES256 = 8;
    localparam int NR_AES256 = 14;

    // Row-major forward S-box; entry 0 sits in the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic bit legal_cfg(input int nk, input int nr);
        return (nk == NK_AES128 && nr == NR_AES128) ||
               (nk == NK_AES192 && nr == NR_AES192) ||
               (nk == NK_AES256 && nr == NR_AES256);
    endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational generator for one key-schedule word: back ^ f(prev), where f depends
// on the position class of the word inside its NK-word group.
module aes_key_word_gen
    import aes_pkg::*;
(
    input  word_t       prev_i,
    input  word_t       back_i,
    input  wcls_e       cls_i,
    input  logic [7:0]  rcon_i,
    output word_t       word_o
);

    word_t sub_in;
    word_t subbed;
    word_t f_val;

    // A single four-S-box SubWord is shared by both the rotated and plain paths.
    always_comb begin
        sub_in = (cls_i == WCLS_ROTSUB) ? rot_word(prev_i) : prev_i;
        subbed = sub_word(sub_in);
        f_val  = prev_i;
        case (cls_i)
            WCLS_ROTSUB: f_val = subbed ^ {rcon_i, 24'h000000};
            WCLS_SUB:    f_val = subbed;
            default:     f_val = prev_i;
        endcase
        word_o = back_i ^ f_val;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key-schedule controller: expands one word per clock into a local store,
// then serves 128-bit round keys to the encrypt and decrypt cores via round-robin arbitration.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NK*32-1:0]  key_in,
    input  logic              start,
    output logic              busy,
    output logic              ready,
    input  logic              enc_req,
    input  logic [3:0]        enc_round,
    input  logic              dec_req,
    input  logic [3:0]        dec_round,
    output logic              enc_gnt,
    output logic              dec_gnt,
    output logic              rk_valid,
    output logic              rk_id,
    output logic [127:0]      rk_data,
    output logic              rk_err
);

    localparam int NW = 4 * (NR + 1);
    localparam bit CFG_OK = legal_cfg(NK, NR);

    state_e       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   mod_q, mod_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         ptr_q, ptr_d;
    logic         rk_valid_q, rk_id_q, rk_err_q;
    logic [127:0] rk_data_q;
    word_t        store_q [NW];

    logic         start_ok;
    logic         load_key;
    logic         write_word;
    wcls_e        cls;
    word_t        new_word;
    logic [3:0]   gnt_round;
    logic         gnt_err;
    logic [5:0]   base;
    logic [127:0] read_key;

    // An illegal NK/NR pairing can never leave IDLE.
    assign start_ok = start && CFG_OK;

    always_comb begin
        cls = WCLS_PLAIN;
        if (mod_q == 3'd0) begin
            cls = WCLS_ROTSUB;
        end else if (NK > 6 && mod_q == 3'd4) begin
            cls = WCLS_SUB;
        end
    end

    aes_key_word_gen u_word_gen (
        .prev_i (store_q[idx_q - 6'd1]),
        .back_i (store_q[idx_q - 6'(NK)]),
        .cls_i  (cls),
        .rcon_i (rcon_q),
        .word_o (new_word)
    );

    // mod_q tracks i%NK incrementally and rcon_q doubles on each use, so no divider is needed.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mod_d      = mod_q;
        rcon_d     = rcon_q;
        load_key   = 1'b0;
        write_word = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start_ok) begin
                    state_d  = ST_EXPAND;
                    idx_d    = 6'(NK);
                    mod_d    = 3'd0;
                    rcon_d   = 8'h01;
                    load_key = 1'b1;
                end
            end
            ST_EXPAND: begin
                write_word = 1'b1;
                idx_d      = idx_q + 6'd1;
                mod_d      = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
                if (cls == WCLS_ROTSUB) begin
                    rcon_d = xtime(rcon_q);
                end
                if (idx_q == 6'(NW - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        enc_gnt = (state_q == ST_READY) && enc_req && (!dec_req || !ptr_q);
        dec_gnt = (state_q == ST_READY) && dec_req && (!enc_req || ptr_q);
        ptr_d   = ptr_q;
        if (state_q == ST_READY && enc_req && dec_req) begin
            ptr_d = ~ptr_q;
        end
        gnt_round = dec_gnt ? dec_round : enc_round;
        gnt_err   = gnt_round > 4'(NR);
        base      = gnt_err ? 6'd0 : {gnt_round, 2'b00};
        read_key  = {store_q[base], store_q[base + 6'd1],
                     store_q[base + 6'd2], store_q[base + 6'd3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            mod_q      <= '0;
            rcon_q     <= 8'h01;
            ptr_q      <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_id_q    <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mod_q      <= mod_d;
            rcon_q     <= rcon_d;
            ptr_q      <= ptr_d;
            rk_valid_q <= enc_gnt || dec_gnt;
            if (enc_gnt || dec_gnt) begin
                rk_id_q   <= dec_gnt;
                rk_err_q  <= gnt_err;
                rk_data_q <= gnt_err ? '0 : read_key;
            end else begin
                rk_err_q  <= 1'b0;
            end
        end
    end

    // The store itself carries no reset; READY is only reachable after a full refill.
    always_ff @(posedge clk) begin
        if (load_key) begin
            for (int k = 0; k < NK; k++) begin
                store_q[k] <= key_in[(NK - 1 - k) * 32 +: 32];
            end
        end else if (write_word) begin
            store_q[idx_q] <= new_word;
        end
    end

    assign busy     = (state_q == ST_EXPAND);
    assign ready    = (state_q == ST_READY);
    assign rk_valid = rk_valid_q;
    assign rk_id    = rk_id_q;
    assign rk_err   = rk_err_q;
    assign rk_data  = rk_data_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: one AES-128 and one AES-256 instance, round-key
// reads checked through per-instance expected-result queues.
module tb_aes_key_sched_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R1      = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10     = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R14_256 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [7:0]   RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    typedef struct packed {
        logic         id;
        logic         err;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [127:0] a_key;
    logic a_start, a_busy, a_ready, a_enc_req, a_dec_req, a_enc_gnt, a_dec_gnt;
    logic [3:0] a_enc_round, a_dec_round;
    logic a_rk_valid, a_rk_id, a_rk_err;
    logic [127:0] a_rk_data;

    logic [255:0] b_key;
    logic b_start, b_busy, b_ready, b_enc_req, b_dec_req, b_enc_gnt, b_dec_gnt;
    logic [3:0] b_enc_round, b_dec_round;
    logic b_rk_valid, b_rk_id, b_rk_err;
    logic [127:0] b_rk_data;

    exp_t qa[$];
    exp_t qb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   aCnt, bCnt;
    logic granted;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NK(4), .NR(10)) u_a128 (
        .clk(clk), .rst_n(rst_n), .key_in(a_key), .start(a_start),
        .busy(a_busy), .ready(a_ready),
        .enc_req(a_enc_req), .enc_round(a_enc_round),
        .dec_req(a_dec_req), .dec_round(a_dec_round),
        .enc_gnt(a_enc_gnt), .dec_gnt(a_dec_gnt),
        .rk_valid(a_rk_valid), .rk_id(a_rk_id), .rk_data(a_rk_data), .rk_err(a_rk_err)
    );

    aes_key_sched_ctrl #(.NK(8), .NR(14)) u_a256 (
        .clk(clk), .rst_n(rst_n), .key_in(b_key), .start(b_start),
        .busy(b_busy), .ready(b_ready),
        .enc_req(b_enc_req), .enc_round(b_enc_round),
        .dec_req(b_dec_req), .dec_round(b_dec_round),
        .enc_gnt(b_enc_gnt), .dec_gnt(b_dec_gnt),
        .rk_valid(b_rk_valid), .rk_id(b_rk_id), .rk_data(b_rk_data), .rk_err(b_rk_err)
    );

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Textbook key expansion with explicit division/modulo and an Rcon table.
    function automatic logic [127:0] refRound(input logic [255:0] key, input int nk,
                                              input int nr, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < nk; i++) w[i] = key[(nk - 1 - i) * 32 +: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {RCON[i / nk - 1], 24'h0};
            else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i - nk] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    function automatic exp_t mk(input logic id, input logic err, input logic [127:0] data);
        return {id, err, data};
    endfunction

    task automatic checkOutput(input string tag, input logic [131:0] observed,
                               input logic [131:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives the AES-128 instance on the falling edge, then settles 1 time unit.
    task automatic applyStimulus(input logic start, input logic encReq, input logic [3:0] encRound,
                                 input logic decReq, input logic [3:0] decRound);
        @(negedge clk);
        a_start     = start;
        a_enc_req   = encReq;
        a_enc_round = encRound;
        a_dec_req   = decReq;
        a_dec_round = decRound;
        #1;
    endtask

    // Scoreboard pop plus per-cycle invariants, sampled mid-low-phase.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n === 1'b1) begin
            if (a_rk_valid === 1'b1) begin
                if (qa.size() == 0) checkOutput("a_unexpected_valid", 132'(a_rk_valid), 132'd0);
                else begin
                    e = qa.pop_front();
                    checkOutput("a_rk", 132'({a_rk_id, a_rk_err, a_rk_data}), 132'(e));
                end
            end
            if (b_rk_valid === 1'b1) begin
                if (qb.size() == 0) checkOutput("b_unexpected_valid", 132'(b_rk_valid), 132'd0);
                else begin
                    e = qb.pop_front();
                    checkOutput("b_rk", 132'({b_rk_id, b_rk_err, b_rk_data}), 132'(e));
                end
            end
            checkOutput("a_gnt_exclusive", 132'(a_enc_gnt & a_dec_gnt), 132'd0);
            checkOutput("a_busy_ready_excl", 132'(a_busy & a_ready), 132'd0);
            checkOutput("b_busy_ready_excl", 132'(b_busy & b_ready), 132'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        a_key = K1; a_start = 0; a_enc_req = 0; a_enc_round = 0; a_dec_req = 0; a_dec_round = 0;
        b_key = K256; b_start = 0; b_enc_req = 0; b_enc_round = 0; b_dec_req = 0; b_dec_round = 0;
        #12;
        checkOutput("rst_a_busy", 132'(a_busy), 132'd0);
        checkOutput("rst_a_ready", 132'(a_ready), 132'd0);
        checkOutput("rst_a_rk_valid", 132'(a_rk_valid), 132'd0);
        checkOutput("rst_a_rk_id_err", 132'({a_rk_id, a_rk_err}), 132'd0);
        checkOutput("rst_a_rk_data", 132'(a_rk_data), 132'd0);
        checkOutput("rst_b_busy_ready", 132'({b_busy, b_ready}), 132'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start both instances together; request round 1 and pulse start during EXPAND.
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        b_start = 1'b1;
        aCnt = 0; bCnt = 0; granted = 1'b0;
        for (int c = 0; c < 120 && !(a_ready && b_ready); c++) begin
            applyStimulus(c == 10, (c >= 2) && !granted, 4'd1, 1'b0, 4'd0);
            b_start = 1'b0;
            if (c == 2) qa.push_back(mk(1'b0, 1'b0, R1));
            if (a_busy) aCnt++;
            if (b_busy) bCnt++;
            if (a_busy) checkOutput("no_gnt_while_busy", 132'(a_enc_gnt), 132'd0);
            if (a_ready && a_enc_req && !granted) begin
                checkOutput("gnt_on_ready", 132'(a_enc_gnt), 132'd1);
                granted = 1'b1;
            end
        end
        checkOutput("a_busy_cycles", 132'(aCnt), 132'd40);
        checkOutput("b_busy_cycles", 132'(bCnt), 132'd52);
        checkOutput("a_ready_up", 132'({a_ready, a_busy}), 132'b10);
        checkOutput("b_ready_up", 132'({b_ready, b_busy}), 132'b10);

        @(negedge clk);
        b_dec_req = 1'b1; b_dec_round = 4'd14;
        qb.push_back(mk(1'b1, 1'b0, R14_256));
        #1 checkOutput("b_dec_gnt", 132'(b_dec_gnt), 132'd1);
        @(negedge clk);
        b_dec_req = 1'b0;

        applyStimulus(1'b0, 1'b1, 4'd10, 1'b0, 4'd0);
        qa.push_back(mk(1'b0, 1'b0, R10));
        checkOutput("gnt_r10", 132'(a_enc_gnt), 132'd1);
        applyStimulus(1'b0, 1'b1, 4'd11, 1'b0, 4'd0);
        qa.push_back(mk(1'b0, 1'b1, 128'd0));
        checkOutput("gnt_r11", 132'(a_enc_gnt), 132'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
        qa.push_back(mk(1'b1, 1'b0, K1));
        checkOutput("gnt_dec_r0", 132'({a_enc_gnt, a_dec_gnt}), 132'b01);

        // Held conflict: grants must alternate starting with enc.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 4'd3, 1'b1, 4'd7);
            if (k % 2 == 0) qa.push_back(mk(1'b0, 1'b0, refRound({128'd0, K1}, 4, 10, 3)));
            else            qa.push_back(mk(1'b1, 1'b0, refRound({128'd0, K1}, 4, 10, 7)));
            checkOutput($sformatf("conflict_gnt_%0d", k), 132'({a_enc_gnt, a_dec_gnt}),
                        (k % 2 == 0) ? 132'b10 : 132'b01);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("idle_no_valid", 132'(a_rk_valid), 132'd0);
        checkOutput("idle_data_hold", 132'(a_rk_data), 132'(refRound({128'd0, K1}, 4, 10, 7)));
        checkOutput("qa_drained_1", 132'(qa.size()), 132'd0);

        // Restart from READY with a new key; the same-cycle grant still reads the old schedule.
        a_key = K2;
        applyStimulus(1'b1, 1'b1, 4'd10, 1'b0, 4'd0);
        qa.push_back(mk(1'b0, 1'b0, R10));
        checkOutput("restart_gnt", 132'(a_enc_gnt), 132'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("restart_ready_drop", 132'({a_ready, a_busy}), 132'b01);
        aCnt = 1;
        for (int c = 0; c < 100 && !a_ready; c++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
            if (a_busy) aCnt++;
        end
        checkOutput("restart_busy_cycles", 132'(aCnt), 132'd40);
        applyStimulus(1'b0, 1'b1, 4'd10, 1'b0, 4'd0);
        qa.push_back(mk(1'b0, 1'b0, refRound({128'd0, K2}, 4, 10, 10)));
        checkOutput("restart_gnt_r10", 132'(a_enc_gnt), 132'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("qa_drained_2", 132'(qa.size()), 132'd0);

        // Asynchronous reset between edges in the middle of an expansion.
        a_key = K1;
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_a_busy_ready", 132'({a_busy, a_ready}), 132'd0);
        checkOutput("arst_a_rk_data", 132'(a_rk_data), 132'd0);
        checkOutput("arst_a_rk_flags", 132'({a_rk_valid, a_rk_id, a_rk_err}), 132'd0);
        checkOutput("arst_b_ready", 132'(b_ready), 132'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
            checkOutput("post_rst_no_gnt", 132'(a_enc_gnt), 132'd0);
        end
        applyStimulus(1'b1, 1'b1, 4'd1, 1'b0, 4'd0);
        qa.push_back(mk(1'b0, 1'b0, R1));
        checkOutput("post_rst_idle_no_gnt", 132'(a_enc_gnt), 132'd0);
        for (int c = 0; c < 100 && !a_ready; c++) begin
            applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
            if (!a_ready) checkOutput("post_rst_expand_no_gnt", 132'(a_enc_gnt), 132'd0);
        end
        checkOutput("post_rst_ready_gnt", 132'({a_ready, a_enc_gnt}), 132'b11);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("qa_drained_3", 132'(qa.size()), 132'd0);
        checkOutput("qb_drained", 132'(qb.size()), 132'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequential AES key-schedule controller. It accepts a cipher key, expands it iteratively (one 32-bit word per clock) into an internal round-key store, then serves 128-bit round keys to two requesters: the encrypt core and the decrypt core. A round-robin arbiter shares the single read port between them. It replaces a fully combinational expansion, trading latency for area.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8 → AES-128/192/256)
- NR, 10, number of rounds (10/12/14; must pair with NK)
- Derived localparam NW = 4*(NR+1), the total number of schedule words

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_in  in  NK*32  cipher key, word 0 in the MSBs; sampled when start is accepted
- start  in  1  begin expansion (single-cycle pulse or level)
- busy  out  1  expansion in progress
- ready  out  1  schedule complete and valid; read port enabled
- enc_req  in  1  encrypt-core read request
- enc_round  in  4  round index requested by the encrypt core
- dec_req  in  1  decrypt-core read request
- dec_round  in  4  round index requested by the decrypt core
- enc_gnt  out  1  encrypt request accepted this cycle
- dec_gnt  out  1  decrypt request accepted this cycle
- rk_valid  out  1  rk_data is valid
- rk_id  out  1  owner of rk_data (0 = enc, 1 = dec)
- rk_data  out  128  round key; word 4r in the MSBs
- rk_err  out  1  with rk_valid: requested round > NR, and rk_data = 0

Behaviour:
- Reset (async assert, sync release) clears all state:
  - state = IDLE
  - busy, ready, enc_gnt, dec_gnt, rk_valid, rk_id, rk_err = 0
  - rk_data = 0; round-robin pointer favours enc
  - store contents are don't-care
- FSM has three states: IDLE, EXPAND, READY.
- IDLE:
  - start=1 → load key_in into words 0..NK-1, set word counter i=NK, busy=1, go to EXPAND next cycle.
  - Requests are never granted.
- EXPAND:
  - Each cycle computes w[i] = w[i-NK] ^ f(w[i-1]), writes it, and increments i.
  - f = SubWord(RotWord(x)) ^ Rcon[i/NK] when i%NK==0.
  - f = SubWord(x) when NK>6 and i%NK==4.
  - Otherwise f = x.
  - Rcon is tracked as a running byte doubled in GF(2^8) per use (01,02,…,80,1b,36). No divider.
  - Writing word NW-1 → next cycle busy=0, ready=1, state READY.
  - Expansion takes exactly NW-NK cycles after the start-accept edge: 40 for AES-128, 46 for AES-192, 52 for AES-256.
  - start is ignored while in EXPAND.
  - Requests are held off (no grants) while in EXPAND.
- READY:
  - At most one grant per cycle; enc_gnt and dec_gnt are combinational from req, state and pointer.
  - One requester active → it wins.
  - Both active → the one that did not win last time wins; the pointer updates only on a conflict grant.
  - Grant in cycle t → rk_valid=1 in cycle t+1 with rk_id, rk_data = words 4r..4r+3, and rk_err.
  - No grant → rk_valid=0 next cycle; rk_data holds its last value.
  - A requester keeps req and round stable until granted.
- start in READY:
  - Restarts expansion: ready=0 and busy=1 from the next cycle, key reloaded.
  - A grant issued in the same cycle still returns valid data from the old schedule in t+1.
- Reset mid-EXPAND or mid-read aborts immediately; outputs take their reset values and ready stays 0 until a new start completes.
- busy and ready are never both 1.

Decomposition:
- Shared package aes_pkg holds:
  - S-box function
  - xtime (GF doubling) function
  - RotWord and SubWord functions
  - word typedef (logic [31:0])
  - legal NK/NR pairing constants
- One combinational sub-module, aes_key_word_gen: inputs prev word, back word, i%NK class and Rcon byte; output next word. It uses 4 S-box instances.
- Arbiter and FSM stay inline.

Test Plan:
- AES-128 (NK=4, NR=10), key 2b7e151628aed2a6abf7158809cf4f3c: start → busy for 40 cycles, then ready. Reading enc_round=1 → rk_data a0fafe1788542cb123a339392a6c7605. Reading round 10 → d014f9a8c9ee2589e13f0cc8b6630ca6, both one cycle after grant.
- AES-256 (NK=8, NR=14), key 000102…1e1f: busy for exactly 52 cycles. Reading round 14 → 24fc79ccbf0979e9371ac23c6d68de36.
- Simultaneous enc_req (round 3) and dec_req (round 7) held for 4 cycles:
  - grants alternate enc, dec, enc, dec
  - rk_id sequence 0,1,0,1 with the correct keys
  - no cycle has both grants
- Request during EXPAND, and enc_round=11 with NR=10:
  - no grant until ready rises
  - the out-of-range read returns rk_valid=1, rk_err=1, rk_data=0
- start pulse mid-EXPAND is ignored and the cycle count is unchanged. start in READY with a new key → ready drops next cycle and new round-10 key is correct after 40 cycles.
- rst_n asserted asynchronously mid-EXPAND and between clock edges: all outputs zero immediately. After release, no grants until a fresh start completes.
